// File: rtl/usb_pkg.sv
// Shared USB receive-path definitions: NRZI decoder state type and line constants.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    ERROR
  } nrzi_dec_state_t;

  localparam int unsigned USB_STUFF_LEN  = 6;
  localparam logic        USB_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/nrzi_decoder.sv
// USB NRZI receive decoder with bit-unstuffing and stuff-violation detection.
// Optional NRZI_DEC_STATS_EN adds saturating bit_count / err_count outputs.
module nrzi_decoder
  import usb_pkg::*;
#(
  parameter int unsigned STUFF_LEN  = USB_STUFF_LEN,
  parameter logic        IDLE_LEVEL = USB_IDLE_LEVEL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync_clr,
  input  logic        bit_valid,
  input  logic        line_bit,
  output logic        data_bit,
  output logic        data_valid,
  output logic        stuff_err,
`ifdef NRZI_DEC_STATS_EN
  output logic [15:0] bit_count,
  output logic [15:0] err_count,
`endif
  output logic        active
);

  localparam int unsigned CntW = $clog2(STUFF_LEN + 1);
  localparam logic [CntW-1:0] StuffMax = CntW'(STUFF_LEN);

  nrzi_dec_state_t state_q, state_d;
  logic            prev_q, prev_d;
  logic [CntW-1:0] ones_q, ones_d;
  logic            data_bit_q, data_bit_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic            dec;

  // No transition on the line decodes as a 1.
  assign dec = (line_bit == prev_q);

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    ones_d     = ones_q;
    data_bit_d = data_bit_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (sync_clr) begin
      // Packet start discards any coincident sample.
      state_d = ACTIVE;
      prev_d  = IDLE_LEVEL;
      ones_d  = '0;
    end else if (bit_valid) begin
      prev_d = line_bit;
      unique case (state_q)
        ACTIVE: begin
          if (ones_q < StuffMax) begin
            data_bit_d = dec;
            valid_d    = 1'b1;
            ones_d     = dec ? ones_q + 1'b1 : '0;
          end else if (!dec) begin
            ones_d = '0;
          end else begin
            err_d   = 1'b1;
            ones_d  = '0;
            state_d = ERROR;
          end
        end
        IDLE, ERROR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prev_q     <= IDLE_LEVEL;
      ones_q     <= '0;
      data_bit_q <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      ones_q     <= ones_d;
      data_bit_q <= data_bit_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign data_bit   = data_bit_q;
  assign data_valid = valid_q;
  assign stuff_err  = err_q;
  assign active     = (state_q == ACTIVE);

`ifdef NRZI_DEC_STATS_EN
  logic [15:0] bit_count_q, err_count_q;

  // Counters track the pulses being registered this cycle and survive sync_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_count_q <= '0;
      err_count_q <= '0;
    end else begin
      if (valid_d && bit_count_q != 16'hFFFF) bit_count_q <= bit_count_q + 16'd1;
      if (err_d && err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
    end
  end

  assign bit_count = bit_count_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_nrzi_decoder.sv
// Randomized and directed bench for nrzi_decoder against a behavioural line-level model.
module tb_nrzi_decoder;

  localparam int RunMax = 6;

  logic clk = 1'b0;
  logic rst, sync_clr, bit_valid, line_bit;
  logic data_bit, data_valid, stuff_err, active;
`ifdef NRZI_DEC_STATS_EN
  logic [15:0] bit_count, err_count;
`endif

  nrzi_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .sync_clr  (sync_clr),
    .bit_valid (bit_valid),
    .line_bit  (line_bit),
    .data_bit  (data_bit),
    .data_valid(data_valid),
    .stuff_err (stuff_err),
`ifdef NRZI_DEC_STATS_EN
    .bit_count (bit_count),
    .err_count (err_count),
`endif
    .active    (active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: "armed" means packet decoding enabled, "halted" means a violation seen.
  bit armed, halted, last_level, m_dbit, m_dv, m_err;
  int run_ones;
  int m_bits, m_errs;

  function automatic void model_step(bit r, bit s, bit v, bit l);
    bit same;
    m_dv  = 0;
    m_err = 0;
    if (r) begin
      armed = 0; halted = 0; last_level = 0; run_ones = 0; m_dbit = 0;
      m_bits = 0; m_errs = 0;
      return;
    end
    if (s) begin
      armed = 1; halted = 0; last_level = 0; run_ones = 0;
      return;
    end
    if (!v) return;
    same       = (l == last_level);
    last_level = l;
    if (!armed || halted) return;
    if (run_ones == RunMax) begin
      run_ones = 0;
      if (same) begin
        m_err  = 1;
        halted = 1;
      end
    end else begin
      m_dv     = 1;
      m_dbit   = same;
      run_ones = same ? run_ones + 1 : 0;
    end
    if (m_dv && m_bits < 65535) m_bits++;
    if (m_err && m_errs < 65535) m_errs++;
  endfunction

  task automatic step(input bit r, input bit s, input bit v, input bit l);
    rst = r; sync_clr = s; bit_valid = v; line_bit = l;
    model_step(r, s, v, l);
    @(posedge clk);
    #1;
    check("data_valid", data_valid, m_dv);
    check("stuff_err", stuff_err, m_err);
    check("data_bit", data_bit, m_dbit);
    check("active", active, armed && !halted);
`ifdef NRZI_DEC_STATS_EN
    check("bit_count", bit_count, m_bits);
    check("err_count", err_count, m_errs);
`endif
  endtask

  initial begin
    bit lvl;
    rst = 1; sync_clr = 0; bit_valid = 0; line_bit = 0;
    model_step(1, 0, 0, 0);

    // Reset state
    step(1, 0, 0, 0);
    check("rst_active", active, 0);
    check("rst_dv", data_valid, 0);
    step(0, 0, 1, 0);
    check("idle_no_dv", data_valid, 0);

    // Basic decode: line 0,1,1 -> 1,0,1
    step(0, 1, 0, 0);
    check("sync_active", active, 1);
    step(0, 0, 1, 0); check("dec0_v", data_valid, 1); check("dec0_b", data_bit, 1);
    step(0, 0, 1, 1); check("dec1_v", data_valid, 1); check("dec1_b", data_bit, 0);
    step(0, 0, 1, 1); check("dec2_v", data_valid, 1); check("dec2_b", data_bit, 1);

    // Stuff removal
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 0);
      check("run_b", data_bit, 1);
    end
    step(0, 0, 1, 1); check("stuffed_dropped", data_valid, 0); check("stuffed_noerr", stuff_err, 0);
    step(0, 0, 1, 1); check("post_stuff_v", data_valid, 1); check("post_stuff_b", data_bit, 1);

    // Stuff error from a clean reset
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("err_pulse", stuff_err, 1);
    check("err_no_dv", data_valid, 0);
    check("err_inactive", active, 0);
`ifdef NRZI_DEC_STATS_EN
    check("stat_bits6", bit_count, 6);
    check("stat_err1", err_count, 1);
`endif
    step(0, 0, 1, 1); check("halted_no_dv", data_valid, 0);
    step(0, 1, 0, 0); check("rearm_active", active, 1);

    // Reset mid-packet with four ones in the run
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    step(1, 0, 1, 0);
    check("midrst_dv", data_valid, 0); check("midrst_active", active, 0);
    check("midrst_b", data_bit, 0);
    step(0, 0, 1, 0); check("midrst_quiet", data_valid, 0);

    // Gaps and sync/bit collision
    step(0, 1, 0, 0);
    step(0, 0, 1, 1); check("gap0", data_bit, 0);
    step(0, 0, 0, 0); check("gap_idle", data_valid, 0);
    step(0, 0, 1, 1); check("gap1", data_bit, 1);
    step(0, 1, 1, 1); check("collide_no_dv", data_valid, 0);
    step(0, 0, 1, 0); check("collide_prev0", data_bit, 1);

    // Randomized traffic
    lvl = 0;
    for (int i = 0; i < 3000; i++) begin
      bit r, s, v;
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) lvl = ~lvl;
      step(r, s, v, lvl);
    end

`ifdef NRZI_DEC_STATS_EN
    // Saturation: toggling line decodes as zeros, never stuffs
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    lvl = 0;
    for (int i = 0; i < 65540; i++) begin
      lvl = ~lvl;
      step(0, 0, 1, lvl);
    end
    check("bit_sat", bit_count, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
